div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW ops.
//  Sits beside the ALU in the execute stage. Its result feeds one data input of the result-select mux.
//  The control FSM holds the core while o_busy is high and samples o_result when o_done pulses.
// PARAMETERS
//  DATA_WIDTH  64  operand/result width; word ops use the low 32 bits; must be even and >= 32
// PORTS
//  i_clk       in   1           clock; all state changes on rising edge
//  i_rst       in   1           synchronous, active-high reset
//  i_start     in   1           request; accepted only in a cycle where o_busy = 0
//  i_kill      in   1           abort the in-flight op (pipeline flush)
//  i_op        in   2           00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_word      in   1           1 = W variant (32-bit op, result sign-extended)
//  i_dividend  in   DATA_WIDTH  rs1 value, sampled on accept
//  i_divisor   in   DATA_WIDTH  rs2 value, sampled on accept
//  o_busy      out  1           high from the cycle after accept through the DONE cycle (inclusive)
//  o_done      out  1           one-cycle pulse; o_result valid in that cycle
//  o_result    out  DATA_WIDTH  quotient or remainder; held until the next accept
// BEHAVIOUR
//  Reset: state=IDLE, o_busy=0, o_done=0, o_result=0, all internal registers cleared.
//  FSM states and transitions:
//   IDLE -> CALC on i_start. Operands, op and word flag are latched.
//   CALC -> FIX after N iterations. A counter runs N-1 down to 0; N = 32 if i_word, else DATA_WIDTH.
//   FIX -> DONE. FIX applies the sign correction and the sign-extension.
//   DONE -> IDLE unconditionally; o_done=1 for this cycle only.
//  Latency: i_start high in cycle 0, CALC occupies cycles 1..N, FIX is cycle N+1, o_done in cycle N+2.
//  Signed ops: divide the magnitudes. Negate the quotient if the operand signs differ.
//   The remainder takes the dividend's sign.
//  Word ops: dividend/divisor = low 32 bits, sign-extended (DIVW/REMW) or zero-extended (DIVUW/REMUW).
//   The 32-bit result is sign-extended to DATA_WIDTH in every W case.
//  Divide by zero: quotient = all ones; remainder = dividend (after word truncation/extension).
//  Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
//  Special-case results are identical with or without the fast path; only the latency differs.
//  i_start while o_busy=1: ignored, no state change.
//  i_start in the DONE cycle: ignored. The earliest next accept is the cycle after DONE.
//  i_kill: in any non-IDLE state, go to IDLE next edge; o_done is never pulsed; o_result keeps its old value.
//  i_kill has priority over completion. i_kill with i_start in IDLE: the start is dropped.
//  i_rst mid-operation: same as reset; the op is lost with no o_done.
//  Remainder register width is DATA_WIDTH+1 so the trial subtraction never overflows.
// CONFIGURATION
//  DIV_FAST_PATH_EN defined: on accept, divide-by-zero and signed overflow go IDLE -> DONE.
//   o_done then pulses in cycle 1 with the special-case result.
//  DIV_FAST_PATH_EN undefined: special cases run the full CALC/FIX sequence (latency N+2).
//   FIX overrides the result with the special-case value.
// STRUCTURE
//  Shared package (div_pkg):
//   div_op_t enum {DIV, DIVU, REM, REMU}
//   div_state_t enum {IDLE, CALC, FIX, DONE}
//   WORD_WIDTH = 32
//  Sub-module div_step: combinational single-iteration restoring step.
//   Inputs: partial remainder, next dividend bit, divisor.
//   Outputs: new remainder and quotient bit. Instantiated once inside the CALC datapath.
// TESTING
//  DIVU 100/7, i_word=0 -> o_done in cycle 66 (DATA_WIDTH=64), o_result = 14. REMU same operands -> 2.
//  DIV -7/2 -> o_result = -3 (0xFFFF_FFFF_FFFF_FFFD). REM -7/2 -> -1.
//  DIV 5/0 -> all ones; REM 5/0 -> 5. Run both with and without DIV_FAST_PATH_EN and check the latency.
//  DIV 0x8000_0000_0000_0000 / -1 -> quotient = dividend, REM -> 0.
//   DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
//  DIVUW 0xFFFF_FFFF_0000_000A / 3 -> o_result 3, o_done in cycle 34.
//   A second i_start in cycle 5 is ignored and o_result is unaffected.
//  i_kill in cycle 10 of a DIV -> IDLE next cycle, no o_done, o_result unchanged.
//   A new op started the following cycle completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider (div_unit, div_step).
// Optional feature macro used by div_unit: DIV_FAST_PATH_EN.
package div_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The top bit of diff is the borrow: set means the trial subtraction must be undone.
    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow one cycle after accept.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_kill,
    input  logic [1:0]            i_op,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST_PATH = 1'b1;
`else
    localparam bit FAST_PATH = 1'b0;
`endif

    function automatic logic [W-1:0] sext_word(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = {W{x[WORD_WIDTH-1]}};
        r[WORD_WIDTH-1:0] = x[WORD_WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] extend_operand(input logic [W-1:0] x, input logic word,
                                                    input logic sgn);
        logic [W-1:0] r;
        if (!word) begin
            r = x;
        end else begin
            r = sgn ? {W{x[WORD_WIDTH-1]}} : '0;
            r[WORD_WIDTH-1:0] = x[WORD_WIDTH-1:0];
        end
        return r;
    endfunction

    // dvd is the already word-extended dividend; without dz the case is signed overflow.
    function automatic logic [W-1:0] special_value(input div_op_t op, input logic word,
                                                   input logic [W-1:0] dvd, input logic dz);
        logic [W-1:0] r;
        if (op_is_rem(op)) r = dz ? dvd : '0;
        else               r = dz ? '1  : dvd;
        return word ? sext_word(r) : r;
    endfunction

    div_state_t    state;
    div_op_t       op_q;
    logic          word_q;
    logic [W-1:0]  dividend_q;
    logic [W-1:0]  dvs_q;
    logic [W-1:0]  dvd_q;
    logic [W-1:0]  quo_q;
    logic [W:0]    rem_q;
    logic [CW-1:0] cnt_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          dz_q;
    logic          ovf_q;

    div_op_t      op_in;
    logic         sgn_in;
    logic [W-1:0] ext_a;
    logic [W-1:0] ext_b;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic [W-1:0] most_neg;
    logic         dz_in;
    logic         ovf_in;
    logic [W-1:0] dvd_init;

    assign op_in = div_op_t'(i_op);

    // Operand conditioning at accept: word extension, magnitudes and special-case detection.
    // A word dividend is parked in the top bits so the iteration always consumes from the MSB.
    always_comb begin
        sgn_in   = op_is_signed(op_in);
        ext_a    = extend_operand(i_dividend, i_word, sgn_in);
        ext_b    = extend_operand(i_divisor, i_word, sgn_in);
        a_neg    = sgn_in & ext_a[W-1];
        b_neg    = sgn_in & ext_b[W-1];
        abs_a    = a_neg ? -ext_a : ext_a;
        abs_b    = b_neg ? -ext_b : ext_b;
        most_neg = '0;
        most_neg[W-1] = 1'b1;
        if (i_word) most_neg = {W{1'b1}} << (WORD_WIDTH - 1);
        dz_in    = (ext_b == '0);
        ovf_in   = sgn_in && (ext_a == most_neg) && (ext_b == '1);
        dvd_init = i_word ? (abs_a << (W - WORD_WIDTH)) : abs_a;
    end

    logic [W:0] step_rem;
    logic       step_q;

    div_step #(
        .WIDTH (W)
    ) u_step (
        .rem_in   (rem_q),
        .next_bit (dvd_q[W-1]),
        .divisor  (dvs_q),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;
    logic [W-1:0] norm_result;
    logic [W-1:0] fix_result;

    always_comb begin
        quo_fix     = neg_quo_q ? -quo_q : quo_q;
        rem_fix     = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        norm_result = op_is_rem(op_q) ? rem_fix : quo_fix;
        if (word_q) norm_result = sext_word(norm_result);
        fix_result  = (dz_q || ovf_q) ? special_value(op_q, word_q, dividend_q, dz_q)
                                      : norm_result;
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    // Kill wins over every transition out of a busy state; o_result only moves on completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            op_q       <= DIV;
            word_q     <= 1'b0;
            dividend_q <= '0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            o_result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && !i_kill) begin
                        op_q       <= op_in;
                        word_q     <= i_word;
                        dividend_q <= ext_a;
                        dvs_q      <= abs_b;
                        dvd_q      <= dvd_init;
                        quo_q      <= '0;
                        rem_q      <= '0;
                        cnt_q      <= i_word ? CW'(WORD_WIDTH - 1) : CW'(W - 1);
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        dz_q       <= dz_in;
                        ovf_q      <= ovf_in;
                        if (FAST_PATH && (dz_in || ovf_in)) begin
                            o_result <= special_value(op_in, i_word, ext_a, dz_in);
                            state    <= DONE;
                        end else begin
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_kill) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[W-2:0], step_q};
                        dvd_q <= {dvd_q[W-2:0], 1'b0};
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) state <= FIX;
                    end
                end
                FIX: begin
                    if (i_kill) begin
                        state <= IDLE;
                    end else begin
                        o_result <= fix_result;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-by-cycle reference model plus directed literal checks.
module tb_div_unit;

    localparam int W = 64;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic          i_kill;
    logic [1:0]    i_op;
    logic          i_word;
    logic [W-1:0]  i_dividend;
    logic [W-1:0]  i_divisor;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_result;

    div_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_kill     (i_kill),
        .i_op       (i_op),
        .i_word     (i_word),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // RISC-V division semantics expressed directly with 64-bit arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic        sgn;
        logic [63:0] ea, eb, q, r, res;
        longint      sa, sb;
        sgn = !op[0];
        ea  = w ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        eb  = w ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        sa  = ea;
        sb  = eb;
        if (eb == 64'd0) begin
            q = '1;
            r = ea;
        end else if (sgn && ea == 64'h8000_0000_0000_0000 && eb == '1) begin
            q = ea;
            r = 64'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
        res = op[1] ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic bit isSpecial(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        bit dz, ovf;
        dz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == '1));
        return dz || ovf;
    endfunction

    bit          expBusy = 1'b0;
    bit          expDone = 1'b0;
    logic [63:0] expResult = '0;
    logic [63:0] pendResult = '0;
    int          left = 0;

    // Compare this cycle's outputs, then predict the next cycle from the inputs now applied.
    always @(negedge i_clk) begin
        checkOutput("model busy", 64'(o_busy), 64'(expBusy));
        checkOutput("model done", 64'(o_done), 64'(expDone));
        checkOutput("model result", o_result, expResult);
        if (i_rst) begin
            expBusy   = 1'b0;
            expDone   = 1'b0;
            expResult = '0;
        end else if (!expBusy) begin
            if (i_start && !i_kill) begin
                pendResult = refResult(i_op, i_word, i_dividend, i_divisor);
                expBusy    = 1'b1;
                if (FAST && isSpecial(i_op, i_word, i_dividend, i_divisor)) begin
                    left      = 0;
                    expDone   = 1'b1;
                    expResult = pendResult;
                end else begin
                    left = (i_word ? 32 : 64) + 1;
                end
            end
        end else if (i_kill || expDone) begin
            expBusy = 1'b0;
            expDone = 1'b0;
        end else begin
            left--;
            if (left == 0) begin
                expDone   = 1'b1;
                expResult = pendResult;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
        @(posedge i_clk);
        #2;
        i_op       = op;
        i_word     = w;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
    endtask

    task automatic waitDone(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge i_clk);
            #2;
            i_start = 1'b0;
            lat++;
            if (o_done) seen = 1'b1;
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expRes, input int expLat, input bit pokeDone);
        int lat;
        bit seen;
        applyStimulus(op, w, a, b);
        waitDone(lat, seen);
        checkOutput({name, " done"}, 64'(seen), 64'd1);
        checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, " result"}, o_result, expRes);
        if (pokeDone) begin
            i_start    = 1'b1;
            i_dividend = 64'd99;
            i_divisor  = 64'd1;
            @(posedge i_clk);
            #2;
            i_start = 1'b0;
            checkOutput({name, " start in done ignored"}, 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        int lat;
        bit seen;
        bit sawDone;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_kill     = 1'b0;
        i_op       = 2'b00;
        i_word     = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        checkOutput("reset busy", 64'(o_busy), 64'd0);
        checkOutput("reset done", 64'(o_done), 64'd0);
        checkOutput("reset result", o_result, 64'd0);

        runOp("divu 100/7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0);
        runOp("remu 100/7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 66, 1'b1);
        runOp("div -7/2", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
        runOp("rem -7/2", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0);
        runOp("divu max/16", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
              64'h0FFF_FFFF_FFFF_FFFF, 66, 1'b0);
        runOp("remu max/16", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 66, 1'b0);
        runOp("div 5/0", 2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
              FAST ? 1 : 66, 1'b1);
        runOp("rem 5/0", 2'b10, 1'b0, 64'd5, 64'd0, 64'd5, FAST ? 1 : 66, 1'b0);
        runOp("div ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, FAST ? 1 : 66, 1'b0);
        runOp("rem ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, FAST ? 1 : 66, 1'b0);
        runOp("divw ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, FAST ? 1 : 34, 1'b0);
        runOp("remw -7/2", 2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
        runOp("remuw x/0", 2'b11, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'hABCD_0000_0000_0000,
              64'hFFFF_FFFF_8000_0005, FAST ? 1 : 34, 1'b0);

        // DIVUW with a second request arriving mid-operation
        applyStimulus(2'b01, 1'b1, 64'hFFFF_FFFF_0000_000A, 64'd3);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge i_clk);
            #2;
            lat++;
            if (lat == 5) begin
                i_start    = 1'b1;
                i_dividend = 64'd1000;
                i_divisor  = 64'd7;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) seen = 1'b1;
        end
        checkOutput("divuw done", 64'(seen), 64'd1);
        checkOutput("divuw latency", 64'(lat), 64'd34);
        checkOutput("divuw result", o_result, 64'd3);

        // Kill in cycle 10 of a DIV, then restart the following cycle
        applyStimulus(2'b00, 1'b0, 64'd1000, 64'd3);
        sawDone = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge i_clk);
            #2;
            i_start = 1'b0;
            if (c == 10) i_kill = 1'b1;
            if (o_done) sawDone = 1'b1;
        end
        @(posedge i_clk);
        #2;
        i_kill = 1'b0;
        checkOutput("kill busy", 64'(o_busy), 64'd0);
        checkOutput("kill no done", 64'(sawDone || o_done), 64'd0);
        checkOutput("kill result held", o_result, 64'd3);
        i_op       = 2'b00;
        i_word     = 1'b0;
        i_dividend = 64'd1000;
        i_divisor  = 64'hFFFF_FFFF_FFFF_FFFD;
        i_start    = 1'b1;
        waitDone(lat, seen);
        checkOutput("after kill done", 64'(seen), 64'd1);
        checkOutput("after kill latency", 64'(lat), 64'd66);
        checkOutput("after kill result", o_result, 64'hFFFF_FFFF_FFFF_FEB3);

        // Kill together with start in IDLE drops the start
        @(posedge i_clk);
        #2;
        i_op       = 2'b01;
        i_dividend = 64'd50;
        i_divisor  = 64'd5;
        i_start    = 1'b1;
        i_kill     = 1'b1;
        @(posedge i_clk);
        #2;
        i_start = 1'b0;
        i_kill  = 1'b0;
        checkOutput("kill drops start", 64'(o_busy), 64'd0);

        // Reset in the middle of an operation
        applyStimulus(2'b01, 1'b0, 64'd500, 64'd5);
        repeat (4) begin
            @(posedge i_clk);
            #2;
            i_start = 1'b0;
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        checkOutput("mid reset busy", 64'(o_busy), 64'd0);
        checkOutput("mid reset result", o_result, 64'd0);
        sawDone = 1'b0;
        repeat (70) begin
            @(posedge i_clk);
            #2;
            if (o_done) sawDone = 1'b1;
        end
        checkOutput("mid reset no done", 64'(sawDone), 64'd0);

        repeat (2) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
